// File: rtl/arb_l2_nslv_pkg.sv
// Shared definitions for the NSLV-slave L2 request router.
//   - default slave-select field position and error read data
//   - per-slave data / byte-enable field widths
//   - clog2 helper used to size select fields, tags and FIFO pointers
package arb_l2_nslv_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  localparam int unsigned SEL_LSB_DEF   = 16;
  localparam logic [31:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

  // Smallest r with 2**r >= v; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/arb_l2_tagfifo.sv
// Synchronous tag FIFO holding the target of every outstanding read.
// Ports:
//   clk_i, rst_n_i  clock (rising edge), async active-low reset
//   push, din       write din at tail (ignored when full)
//   pop             drop the head entry (ignored when empty)
//   head            entry at the head pointer
//   count           number of valid entries, 0..DEPTH
//   full, empty     count == DEPTH / count == 0
module arb_l2_tagfifo
  import arb_l2_nslv_pkg::*;
#(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [clog2(DEPTH):0]    count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PW = clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[head_q];
  assign count = count_q;

  // DEPTH is a power of two, so pointer increments wrap on their own.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    push_ok = push && !full;
    pop_ok  = pop && !empty;
    if (push_ok) begin
      mem_d[tail_q] = din;
      tail_d        = tail_q + PW'(1);
    end
    if (pop_ok) begin
      head_d = head_q + PW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mem_q   <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/arb_l2_nslv.sv
// Single-master to NSLV-slave request router with in-order read tracking.
// The slave index is decoded from m_addr[SEL_LSB +: clog2(NSLV)]; indices
// >= NSLV are terminated locally with an immediate ack and an ERR_RDATA
// read response. Up to DEPTH reads may be outstanding, all to one target.
// Ports:
//   clk_i, rst_n_i              clock, async active-low reset
//   m_req/m_we/m_addr/m_wdata/m_be   master request
//   m_ack                       request accepted (combinational)
//   m_resp, m_rdata             read response to master (combinational)
//   s_req/s_we/s_addr/s_wdata/s_be   per-slave request, slave k at bit k /
//                               [32k +: 32] / [4k +: 4]
//   s_ack, s_resp, s_rdata      per-slave accept, read valid, read data
module arb_l2_nslv
  import arb_l2_nslv_pkg::*;
#(
  parameter int unsigned NSLV      = 4,
  parameter int unsigned SEL_LSB   = SEL_LSB_DEF,
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     m_req,
  input  logic                     m_we,
  input  logic [31:0]              m_addr,
  input  logic [31:0]              m_wdata,
  input  logic [3:0]               m_be,
  output logic                     m_ack,
  output logic                     m_resp,
  output logic [31:0]              m_rdata,
  output logic [NSLV-1:0]          s_req,
  output logic [NSLV-1:0]          s_we,
  output logic [DATA_W*NSLV-1:0]   s_addr,
  output logic [DATA_W*NSLV-1:0]   s_wdata,
  output logic [BE_W*NSLV-1:0]     s_be,
  input  logic [NSLV-1:0]          s_ack,
  input  logic [NSLV-1:0]          s_resp,
  input  logic [DATA_W*NSLV-1:0]   s_rdata
);

  localparam int unsigned SELW = clog2(NSLV);
  localparam int unsigned TW   = SELW + 1;
  localparam logic [TW-1:0] ERR_TAG = TW'(NSLV);

  logic [SELW-1:0]        sel;
  logic [TW-1:0]          tag;
  logic                   sel_err;
  logic [TW-1:0]          last_tag_q, last_tag_d;
  logic                   gate, route, push, pop;
  logic [TW-1:0]          head_tag;
  logic [SELW-1:0]        head_sel;
  logic [clog2(DEPTH):0]  fifo_count;
  logic                   fifo_full, fifo_empty;

  assign sel      = m_addr[SEL_LSB +: SELW];
  assign sel_err  = ({1'b0, sel} >= ERR_TAG);
  assign tag      = sel_err ? ERR_TAG : {1'b0, sel};
  assign head_sel = head_tag[SELW-1:0];

  // All outstanding reads share one target, so responses cannot reorder.
  assign gate  = !fifo_full && ((fifo_count == '0) || (tag == last_tag_q));
  assign route = m_req && (m_we || gate);
  assign push  = m_req && !m_we && m_ack;
  assign pop   = m_resp;

  always_comb begin
    s_req   = '0;
    s_we    = '0;
    s_addr  = '0;
    s_wdata = '0;
    s_be    = '0;
    m_ack   = 1'b0;
    if (route) begin
      if (sel_err) begin
        m_ack = 1'b1;
      end else begin
        s_req[sel]                   = 1'b1;
        s_we[sel]                    = m_we;
        s_addr[DATA_W*sel +: DATA_W] = m_addr;
        s_wdata[DATA_W*sel +: DATA_W] = m_wdata;
        s_be[BE_W*sel +: BE_W]       = m_be;
        m_ack                        = s_ack[sel];
      end
    end
  end

  // With no read outstanding every s_resp is ignored.
  always_comb begin
    m_resp  = 1'b0;
    m_rdata = '0;
    if (!fifo_empty) begin
      if (head_tag < ERR_TAG) begin
        m_resp  = s_resp[head_sel];
        m_rdata = s_rdata[DATA_W*head_sel +: DATA_W];
      end else begin
        m_resp  = 1'b1;
        m_rdata = ERR_RDATA;
      end
    end
  end

  always_comb begin
    last_tag_d = push ? tag : last_tag_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) last_tag_q <= '0;
    else          last_tag_q <= last_tag_d;
  end

  arb_l2_tagfifo #(
    .WIDTH (TW),
    .DEPTH (DEPTH)
  ) u_tagfifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push    (push),
    .din     (tag),
    .pop     (pop),
    .head    (head_tag),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_arb_l2_nslv.sv
module tb_arb_l2_nslv;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Main DUT: NSLV=4, DEPTH=4
  logic         m_req, m_we;
  logic [31:0]  m_addr, m_wdata;
  logic [3:0]   m_be;
  logic         m_ack, m_resp;
  logic [31:0]  m_rdata;
  logic [3:0]   s_req, s_we;
  logic [127:0] s_addr, s_wdata;
  logic [15:0]  s_be;
  logic [3:0]   s_ack, s_resp;
  logic [127:0] s_rdata;

  // Second DUT: NSLV=3, exercises the error target
  logic         m3_req, m3_we;
  logic [31:0]  m3_addr, m3_wdata;
  logic [3:0]   m3_be;
  logic         m3_ack, m3_resp;
  logic [31:0]  m3_rdata;
  logic [2:0]   s3_req, s3_we;
  logic [95:0]  s3_addr, s3_wdata;
  logic [11:0]  s3_be;
  logic [2:0]   s3_ack, s3_resp;
  logic [95:0]  s3_rdata;

  arb_l2_nslv #(.NSLV(4), .SEL_LSB(16), .DEPTH(4), .ERR_RDATA(32'hDEADBEEF)) u_dut4 (
    .clk_i(clk), .rst_n_i(rst_n),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_ack(m_ack), .m_resp(m_resp), .m_rdata(m_rdata),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_be(s_be),
    .s_ack(s_ack), .s_resp(s_resp), .s_rdata(s_rdata)
  );

  arb_l2_nslv #(.NSLV(3), .SEL_LSB(16), .DEPTH(4), .ERR_RDATA(32'hDEADBEEF)) u_dut3 (
    .clk_i(clk), .rst_n_i(rst_n),
    .m_req(m3_req), .m_we(m3_we), .m_addr(m3_addr), .m_wdata(m3_wdata), .m_be(m3_be),
    .m_ack(m3_ack), .m_resp(m3_resp), .m_rdata(m3_rdata),
    .s_req(s3_req), .s_we(s3_we), .s_addr(s3_addr), .s_wdata(s3_wdata), .s_be(s3_be),
    .s_ack(s3_ack), .s_resp(s3_resp), .s_rdata(s3_rdata)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model of the NSLV=4 DUT: a queue of outstanding read targets.
  int mq[$];
  int mlt = 0;

  initial begin
    int           sel;
    bit           open, exp_ack, exp_resp, do_push, do_pop;
    logic [3:0]   e_req, e_we;
    logic [127:0] e_addr, e_wdata;
    logic [15:0]  e_be;
    logic [31:0]  exp_rdata;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mq.delete();
        mlt = 0;
      end
      sel  = int'(m_addr[17:16]);
      open = m_req && (m_we || (mq.size() < 4 && (mq.size() == 0 || sel == mlt)));
      e_req = '0; e_we = '0; e_addr = '0; e_wdata = '0; e_be = '0;
      exp_ack = 1'b0;
      if (open) begin
        e_req[sel] = 1'b1;
        e_we[sel]  = m_we;
        e_addr[32*sel +: 32]  = m_addr;
        e_wdata[32*sel +: 32] = m_wdata;
        e_be[4*sel +: 4]      = m_be;
        exp_ack = s_ack[sel];
      end
      exp_resp  = 1'b0;
      exp_rdata = '0;
      if (mq.size() > 0) begin
        exp_resp  = s_resp[mq[0]];
        exp_rdata = s_rdata[32*mq[0] +: 32];
      end
      chk("mdl_s_req",   s_req,   e_req);
      chk("mdl_s_we",    s_we,    e_we);
      chk("mdl_s_addr",  s_addr,  e_addr);
      chk("mdl_s_wdata", s_wdata, e_wdata);
      chk("mdl_s_be",    s_be,    e_be);
      chk("mdl_m_ack",   m_ack,   exp_ack);
      chk("mdl_m_resp",  m_resp,  exp_resp);
      chk("mdl_m_rdata", m_rdata, exp_rdata);
      do_push = open && !m_we && exp_ack;
      do_pop  = exp_resp;
      @(posedge clk);
      if (rst_n) begin
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
          mq.push_back(sel);
          mlt = sel;
        end
      end
    end
  end

  logic [31:0] rd [4];

  initial begin
    rd = '{32'h11, 32'h22, 32'h33, 32'h44};
    rst_n = 1'b0;
    m_req = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_be = '0;
    s_ack = '0; s_resp = '0; s_rdata = '0;
    m3_req = 0; m3_we = 0; m3_addr = '0; m3_wdata = '0; m3_be = '0;
    s3_ack = '0; s3_resp = '0; s3_rdata = '0;
    #1;
    chk("rst_m_resp", m_resp, 1'b0);
    chk("rst_m_rdata", m_rdata, 32'h0);
    chk("rst_m_ack", m_ack, 1'b0);
    repeat (2) step();
    rst_n = 1'b1;

    // Write to slave 2
    m_req = 1; m_we = 1; m_addr = 32'h0002_0010; m_wdata = 32'hCAFE_0001; m_be = 4'hF;
    s_ack = 4'b0100;
    #1;
    chk("wr_s_req", s_req, 4'b0100);
    chk("wr_s_addr2", s_addr[95:64], 32'h0002_0010);
    chk("wr_s_wdata2", s_wdata[95:64], 32'hCAFE_0001);
    chk("wr_m_ack", m_ack, 1'b1);
    s_ack = 4'b0000;
    #1;
    chk("wr_m_ack_follow", m_ack, 1'b0);
    s_ack = 4'b0100;
    step();
    m_req = 0; m_we = 0;
    #1;
    chk("wr_no_resp", m_resp, 1'b0);
    chk("wr_model_cnt", mq.size(), 0);

    // Four pipelined reads to slave 1, fifth refused
    s_ack = 4'hF;
    for (int i = 0; i < 4; i++) begin
      m_addr = 32'h0001_0000 + 32'(4 * i);
      m_req  = 1;
      #1;
      chk("rd_ack", m_ack, 1'b1);
      step();
    end
    m_addr = 32'h0001_0010;
    #1;
    chk("rd5_ack", m_ack, 1'b0);
    chk("rd5_s_req", s_req, 4'b0000);
    chk("rd_model_cnt4", mq.size(), 4);
    m_req = 0;
    for (int i = 0; i < 4; i++) begin
      s_rdata[63:32] = rd[i];
      s_resp = 4'b0010;
      #1;
      chk("rd_resp", m_resp, 1'b1);
      chk("rd_rdata", m_rdata, rd[i]);
      step();
    end
    s_resp = '0;
    #1;
    chk("rd_drained", m_resp, 1'b0);
    chk("rd_drained_rdata", m_rdata, 32'h0);

    // Same-cycle push and pop at count 2
    m_addr = 32'h0001_0000; m_req = 1;
    step();
    step();
    s_rdata[63:32] = 32'h55; s_resp = 4'b0010;
    #1;
    chk("pp_ack", m_ack, 1'b1);
    chk("pp_resp", m_resp, 1'b1);
    chk("pp_rdata", m_rdata, 32'h55);
    step();
    m_req = 0;
    #1;
    chk("pp_model_cnt2", mq.size(), 2);
    s_rdata[63:32] = 32'h66;
    #1;
    chk("pp_drain1", m_resp, 1'b1);
    step();
    s_rdata[63:32] = 32'h77;
    #1;
    chk("pp_drain2", m_resp, 1'b1);
    step();
    chk("pp_empty", m_resp, 1'b0);
    s_resp = '0;

    // Reset mid-burst
    m_addr = 32'h0002_0000; m_req = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rb_ack", m_ack, 1'b1);
      step();
    end
    m_req = 0;
    s_rdata[95:64] = 32'h99; s_resp = 4'b0100;
    #1;
    chk("rb_pre_resp", m_resp, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rb_rst_resp", m_resp, 1'b0);
    chk("rb_rst_rdata", m_rdata, 32'h0);
    step();
    rst_n = 1'b1;
    #1;
    chk("rb_stray", m_resp, 1'b0);
    step();
    chk("rb_stray2", m_resp, 1'b0);
    s_resp = '0;

    // Read to slave 0 outstanding holds a read to slave 3
    m_addr = 32'h0000_0000; m_req = 1;
    #1;
    chk("hold_rd0_ack", m_ack, 1'b1);
    step();
    m_addr = 32'h0003_0000;
    #1;
    chk("hold_ack", m_ack, 1'b0);
    chk("hold_s_req", s_req, 4'b0000);
    step();
    chk("hold_ack2", m_ack, 1'b0);
    s_rdata[31:0] = 32'h77; s_resp = 4'b0001;
    #1;
    chk("hold_resp0", m_resp, 1'b1);
    chk("hold_rdata0", m_rdata, 32'h77);
    chk("hold_ack3", m_ack, 1'b0);
    step();
    s_resp = '0;
    #1;
    chk("rel_ack", m_ack, 1'b1);
    chk("rel_s_req", s_req, 4'b1000);
    step();
    m_req = 0;
    s_rdata[127:96] = 32'h88; s_resp = 4'b1000;
    #1;
    chk("rel_resp3", m_resp, 1'b1);
    chk("rel_rdata3", m_rdata, 32'h88);
    step();
    s_resp = '0;
    #1;
    chk("rel_empty", m_resp, 1'b0);

    // Error target on NSLV=3
    m3_req = 1; m3_we = 0; m3_addr = 32'h0003_0000;
    #1;
    chk("err_ack", m3_ack, 1'b1);
    chk("err_s_req", s3_req, 3'b000);
    chk("err_resp_early", m3_resp, 1'b0);
    step();
    m3_req = 0;
    #1;
    chk("err_resp", m3_resp, 1'b1);
    chk("err_rdata", m3_rdata, 32'hDEADBEEF);
    step();
    chk("err_done", m3_resp, 1'b0);
    chk("err_done_rdata", m3_rdata, 32'h0);

    step();
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
